// File: rtl/gemm_feed_ctrl_pkg.sv
// Shared types and defaults for the GEMM row-FIFO read scheduler.
package gemm_feed_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} feed_state_t;

    localparam int FEED_ROWS = 4;

endpackage

// File: rtl/gemm_feed_ctrl_if.sv
// Control/feed bundle between the GEMM top FSM, the row FIFOs and the read scheduler.
interface gemm_feed_ctrl_if
    import gemm_feed_ctrl_pkg::*;
#(
    parameter int N     = FEED_ROWS,
    parameter int LEN_W = 4
);
    logic             start;
    logic [LEN_W-1:0] tile_len;
    logic             abort;
    logic [N-1:0]     buf_empty;
    logic [N-1:0]     rd_en;
    logic             busy;
    logic             stall;
    logic             done;

    modport master (
        output start, tile_len, abort, buf_empty,
        input  rd_en, busy, stall, done
    );

    modport slave (
        input  start, tile_len, abort, buf_empty,
        output rd_en, busy, stall, done
    );
endinterface

// File: rtl/gemm_feed_ctrl.sv
// Drains tile_len entries from each row FIFO with a one-cycle-per-row diagonal skew,
// freezing the whole schedule whenever a due FIFO is empty.
module gemm_feed_ctrl
    import gemm_feed_ctrl_pkg::*;
#(
    parameter int N     = FEED_ROWS,
    parameter int DEPTH = 8,
    parameter int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    gemm_feed_ctrl_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + N) + 1;

    feed_state_t      r_state;
    logic [CW-1:0]    r_cnt;
    logic [LEN_W-1:0] r_len;
    logic             r_busy;
    logic             r_done;

    logic [N-1:0]     w_win;
    logic             w_run;
    logic             w_stall;
    logic             w_last;
    logic [LEN_W-1:0] w_len_sat;

    assign w_run     = (r_state == RUN);
    assign w_len_sat = (bus.tile_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.tile_len;

    // Row i is due while cnt sits in [i, i+len_q); this produces the diagonal skew.
    for (genvar gi = 0; gi < N; gi++) begin : g_win
        assign w_win[gi] = (r_cnt >= CW'(gi)) && (r_cnt < CW'(gi) + CW'(r_len));
    end

    assign w_stall = w_run && |(w_win & bus.buf_empty);
    // Last read cycle is when the bottom row consumes its final entry.
    assign w_last  = (r_cnt == CW'(r_len) + CW'(N) - CW'(2));

    assign bus.rd_en = (w_run && !w_stall) ? w_win : '0;
    assign bus.stall = w_stall;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.abort) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_len  <= w_len_sat;
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                        if (bus.tile_len == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (!w_stall) begin
                        if (w_last) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
